// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, defaults and write-match helper for the register-file read path
package regfile_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int ZR_IDX_DEF = 31;
  localparam int NRP_DEF = 2;
  localparam int AW_DEF = $clog2(NREG_DEF);
  typedef logic [WIDTH_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0] rix_t;
  typedef struct packed {
    logic valid;
    rix_t [NRP_DEF-1:0] addr;
    word_t [NRP_DEF-1:0] data;
  } rd_stage_t;
  // A write targets a read index unless it aims at the hard-wired zero register
  function automatic logic wr_hit(input logic en, input logic [31:0] wa, input logic [31:0] ra,
                                  input logic zr_en, input logic [31:0] zr);
    return en && wa == ra && !(zr_en && wa == zr);
  endfunction
endpackage

// File: rtl/regfile_read_pipe_if.sv
// regfile_read_pipe_if: request/response handshake bundle between decode, read pipe and execute
interface regfile_read_pipe_if import regfile_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP = NRP_DEF,
    localparam int AW = $clog2(NREG)
);
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic [NRP*AW-1:0] rd_addr;
    logic [NRP*WIDTH-1:0] rd_data;
    modport master (output in_valid, rd_addr, out_ready, input in_ready, out_valid, rd_data);
    modport slave (input in_valid, rd_addr, out_ready, output in_ready, out_valid, rd_data);
endinterface

// File: rtl/regfile_mux_n.sv
// regfile_mux_n: combinational N-to-1 word select; out-of-range index yields zero
module regfile_mux_n #(
    parameter int WIDTH = 64,
    parameter int N = 32,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*WIDTH-1:0] d,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   q
);
    assign q = (int'(sel) < N) ? d[sel*WIDTH +: WIDTH] : '0;
endmodule

// File: rtl/regfile_read_pipe.sv
// regfile_read_pipe: multi-port register read with write bypass, in-flight snoop and valid/ready pipeline
module regfile_read_pipe import regfile_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP = 2,
    parameter int STAGES = 1,
    parameter int HAS_ZR = 1,
    parameter int ZR_IDX = ZR_IDX_DEF,
    localparam int AW = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREG*WIDTH-1:0] regs,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    regfile_read_pipe_if.slave    bus
);
    localparam int L = STAGES - 1;
    localparam logic ZE = (HAS_ZR != 0);
    if (STAGES != 1 && STAGES != 2) begin : g_bad
        $error("regfile_read_pipe: STAGES must be 1 or 2");
    end
    logic [NRP-1:0][AW-1:0] ra;
    logic [NRP-1:0][WIDTH-1:0] mux_q, acc;
    logic [STAGES-1:0] sv;
    logic [NRP-1:0][AW-1:0] sa [STAGES];
    logic [NRP-1:0][WIDTH-1:0] sd [STAGES];
    logic [NRP-1:0][WIDTH-1:0] snp [STAGES];
    logic adv_l, adv_f;
    assign ra = bus.rd_addr;
    for (genvar p = 0; p < NRP; p++) begin : g_port
        regfile_mux_n #(.WIDTH(WIDTH), .N(NREG)) u_mux (.d(regs), .sel(ra[p]), .q(mux_q[p]));
    end
    function automatic logic hit(input logic [AW-1:0] a);
        return wr_hit(wr_en, 32'(wr_addr), 32'(a), ZE, 32'(ZR_IDX));
    endfunction
    always_comb begin
        for (int p = 0; p < NRP; p++)
            acc[p] = hit(ra[p]) ? wr_data : (ZE && ra[p] == AW'(ZR_IDX)) ? '0 : mux_q[p];
    end
    // Snooped view of each stage: what it would hold after this edge's write
    always_comb begin
        for (int s = 0; s < STAGES; s++)
            for (int p = 0; p < NRP; p++)
                snp[s][p] = (sv[s] && hit(sa[s][p])) ? wr_data : sd[s][p];
    end
    assign adv_l = !sv[L] || bus.out_ready;
    assign adv_f = (STAGES == 1) ? adv_l : (!sv[0] || adv_l);
    assign bus.in_ready = adv_f;
    assign bus.out_valid = sv[L];
    assign bus.rd_data = sd[L];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            for (int s = 0; s < STAGES; s++) begin
                sa[s] <= '0;
                sd[s] <= '0;
            end
        end else begin
            if (STAGES == 2) begin
                if (adv_l) sv[L] <= sv[0];
                if (adv_l && sv[0]) begin
                    sa[L] <= sa[0];
                    sd[L] <= snp[0];
                end else sd[L] <= snp[L];
            end
            if (adv_f) sv[0] <= bus.in_valid;
            if (adv_f && bus.in_valid) begin
                sa[0] <= ra;
                sd[0] <= acc;
            end else sd[0] <= snp[0];
        end
    end
endmodule

// File: tb/tb_regfile_read_pipe.sv
// tb_regfile_read_pipe: directed vector table plus hand sequences on one- and two-stage instances
module tb_regfile_read_pipe;
    import regfile_pkg::*;
    localparam int W = 64;
    localparam int N = 32;
    localparam int P = 2;
    localparam int A = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*W-1:0] regs;
    logic wr_en;
    logic [A-1:0] wr_addr;
    word_t wr_data;
    int total = 0;
    int bad = 0;
    regfile_read_pipe_if #(.WIDTH(W), .NREG(N), .NRP(P)) b1 ();
    regfile_read_pipe_if #(.WIDTH(W), .NREG(N), .NRP(P)) b2 ();
    regfile_read_pipe #(.STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .regs(regs), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .bus(b1));
    regfile_read_pipe #(.STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .regs(regs), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .bus(b2));
    always #5 clk = ~clk;
    typedef struct {
        logic [A-1:0] a0, a1;
        logic we;
        logic [A-1:0] wa;
        word_t wd, e0, e1;
    } vec_t;
    vec_t tv [7];
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask
    task automatic set_reg(input int r, input word_t v);
        regs[r*W +: W] = v;
    endtask
    task automatic base_regs();
        for (int r = 0; r < N; r++) set_reg(r, 64'h1000 + 64'(r));
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        tv[0] = '{5'd5,  5'd9,  1'b0, 5'd0,  64'h0,    64'h1111, 64'h2222};
        tv[1] = '{5'd31, 5'd9,  1'b1, 5'd31, 64'hDEAD, 64'h0,    64'h2222};
        tv[2] = '{5'd7,  5'd7,  1'b1, 5'd7,  64'hABCD, 64'hABCD, 64'hABCD};
        tv[3] = '{5'd3,  5'd12, 1'b0, 5'd0,  64'h0,    64'h1003, 64'h100C};
        tv[4] = '{5'd0,  5'd31, 1'b1, 5'd0,  64'h5555, 64'h5555, 64'h0};
        tv[5] = '{5'd7,  5'd20, 1'b1, 5'd20, 64'h77,   64'h0,    64'h77};
        tv[6] = '{5'd31, 5'd31, 1'b0, 5'd0,  64'h0,    64'h0,    64'h0};
        base_regs();
        set_reg(5, 64'h1111);
        set_reg(9, 64'h2222);
        set_reg(31, 64'hFFFF);
        set_reg(7, 64'h0);
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        b1.in_valid = 1'b0; b1.rd_addr = '0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.rd_addr = '0; b2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid1", 128'(b1.out_valid), 128'd0);
        chk("rst_rd_data1", b1.rd_data, 128'd0);
        chk("rst_in_ready1", 128'(b1.in_ready), 128'd1);
        chk("rst_out_valid2", 128'(b2.out_valid), 128'd0);
        chk("rst_rd_data2", b2.rd_data, 128'd0);
        rst_n = 1'b1;
        step();
        // Single requests through the one-stage pipe
        for (int i = 0; i < 7; i++) begin
            b1.in_valid = 1'b1;
            b1.rd_addr = {tv[i].a1, tv[i].a0};
            wr_en = tv[i].we;
            wr_addr = tv[i].wa;
            wr_data = tv[i].wd;
            step();
            b1.in_valid = 1'b0;
            wr_en = 1'b0;
            chk($sformatf("vec%0d_valid", i), 128'(b1.out_valid), 128'd1);
            chk($sformatf("vec%0d_data", i), b1.rd_data, {tv[i].e1, tv[i].e0});
            step();
            chk($sformatf("vec%0d_drain", i), 128'(b1.out_valid), 128'd0);
        end
        // Output stage stalled, then snooped by a write
        set_reg(3, 64'h10);
        b1.out_ready = 1'b0;
        b1.rd_addr = {5'd3, 5'd3};
        b1.in_valid = 1'b1;
        step();
        b1.in_valid = 1'b0;
        chk("stall_valid", 128'(b1.out_valid), 128'd1);
        chk("stall_data", b1.rd_data, {64'h10, 64'h10});
        chk("stall_in_ready", 128'(b1.in_ready), 128'd0);
        step();
        chk("stall_hold", b1.rd_data, {64'h10, 64'h10});
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h20;
        step();
        wr_en = 1'b0;
        chk("snoop_valid", 128'(b1.out_valid), 128'd1);
        chk("snoop_data", b1.rd_data, {64'h20, 64'h20});
        chk("snoop_in_ready", 128'(b1.in_ready), 128'd0);
        b1.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 128'(b1.in_ready), 128'd1);
        step();
        chk("deliver_once", 128'(b1.out_valid), 128'd0);
        // Two-stage back-to-back stream with a write hitting the first stage
        base_regs();
        for (int k = 0; k < 10; k++) begin
            b2.in_valid = (k < 8);
            b2.rd_addr = {5'(k + 8), 5'(k)};
            wr_en = (k == 4);
            wr_addr = 5'd3;
            wr_data = 64'hBEEF;
            step();
            chk($sformatf("tp%0d_valid", k), 128'(b2.out_valid), 128'((k >= 1) && (k <= 8)));
            chk($sformatf("tp%0d_in_ready", k), 128'(b2.in_ready), 128'd1);
            if (k >= 1 && k <= 8)
                chk($sformatf("tp%0d_data", k), b2.rd_data,
                    {64'h1000 + 64'(k + 7), (k == 4) ? 64'hBEEF : 64'h1000 + 64'(k - 1)});
        end
        b2.in_valid = 1'b0;
        wr_en = 1'b0;
        // Reset with both stages occupied
        b2.out_ready = 1'b0;
        b2.in_valid = 1'b1;
        b2.rd_addr = {5'd2, 5'd1};
        step();
        b2.rd_addr = {5'd4, 5'd3};
        step();
        b2.in_valid = 1'b0;
        chk("mid_valid", 128'(b2.out_valid), 128'd1);
        chk("mid_in_ready", 128'(b2.in_ready), 128'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(b2.out_valid), 128'd0);
        chk("arst_data", b2.rd_data, 128'd0);
        chk("arst_in_ready", 128'(b2.in_ready), 128'd1);
        #3 rst_n = 1'b1;
        set_reg(5, 64'h1111);
        set_reg(9, 64'h2222);
        b2.out_ready = 1'b1;
        b2.in_valid = 1'b1;
        b2.rd_addr = {5'd5, 5'd9};
        step();
        b2.in_valid = 1'b0;
        chk("post_rst_early", 128'(b2.out_valid), 128'd0);
        step();
        chk("post_rst_valid", 128'(b2.out_valid), 128'd1);
        chk("post_rst_data", b2.rd_data, {64'h1111, 64'h2222});
        step();
        chk("post_rst_drain", 128'(b2.out_valid), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
